// File: rtl/rgb_pixel_streamer_pkg.sv
// Shared pixel-format and FSM definitions for the edge-detection pipeline.
// rgb_to_grayscale and later stages import the same lane constants.
package rgb_pixel_streamer_pkg;

    localparam int unsigned PIXEL_W = 8;
    localparam int unsigned RGB_W   = 24;

    localparam int unsigned R_MSB = 23;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

endpackage

// File: rtl/rgb_pixel_streamer_coord.sv
// Column/row position of the pixel currently returning from memory,
// with wrap at the end of each row and end-of-frame flags.
module pixel_coord_counter #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned COL_W      = $clog2(IMG_WIDTH),
    parameter int unsigned ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_col,
    output logic             last_pix
);

    always_comb begin
        last_col = (col == COL_W'(IMG_WIDTH - 1));
        last_pix = last_col && (row == ROW_W'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_pixel_streamer.sv
// Frame source: raster-order reads of packed RGB pixels from a synchronous
// memory, emitted one per cycle with sof/eol/eof framing.
module rgb_pixel_streamer
    import rgb_pixel_streamer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [RGB_W-1:0]  mem_data_i,
    output logic [PIXEL_W-1:0] red_o,
    output logic [PIXEL_W-1:0] green_o,
    output logic [PIXEL_W-1:0] blue_o,
    output logic              done_o,
    output logic              sof_o,
    output logic              eol_o,
    output logic              eof_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int unsigned NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned COL_W   = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_PIX - 1);

    stream_state_t state, state_nxt;
    logic          issue;
    logic          coord_clear;
    logic          pend;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic          last_col;
    logic          last_pix;

    // Coordinates follow returning data (pend), not issued addresses, so
    // holds between issue and return cannot skew the framing flags.
    pixel_coord_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_coord (
        .clk      (clk),
        .rst      (rst),
        .clear    (coord_clear),
        .en       (pend),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        coord_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt   = ST_RUN;
                    issue       = 1'b1;
                    coord_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (!hold_i) begin
                    issue = 1'b1;
                    if (mem_addr_o + ADDR_W'(1) == LAST_ADDR) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (done_o && eof_o) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem_en_o     <= 1'b0;
            mem_addr_o   <= '0;
            pend         <= 1'b0;
            red_o        <= '0;
            green_o      <= '0;
            blue_o       <= '0;
            done_o       <= 1'b0;
            sof_o        <= 1'b0;
            eol_o        <= 1'b0;
            eof_o        <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_en_o <= issue;
            if (issue) begin
                mem_addr_o <= (state == ST_IDLE) ? FIRST_ADDR : mem_addr_o + ADDR_W'(1);
            end
            pend    <= mem_en_o;
            done_o  <= pend;
            red_o   <= pend ? mem_data_i[R_MSB:R_LSB] : '0;
            green_o <= pend ? mem_data_i[G_MSB:G_LSB] : '0;
            blue_o  <= pend ? mem_data_i[B_MSB:B_LSB] : '0;
            sof_o   <= pend && (col == '0) && (row == '0);
            eol_o   <= pend && last_col;
            eof_o   <= pend && last_pix;
            busy_o       <= (state_nxt != ST_IDLE);
            frame_done_o <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_rgb_pixel_streamer.sv
// Randomized bench for rgb_pixel_streamer against a frame-level reference model.
module tb_rgb_pixel_streamer;

    localparam int unsigned W      = 4;
    localparam int unsigned H      = 2;
    localparam int unsigned NPIX   = W * H;
    localparam int unsigned AW     = 19;
    localparam int unsigned BASE   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_data = '0;
    logic [7:0]    red, green, blue;
    logic          done, sof, eol, eof, busy, frame_done;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Reference model state
    int unsigned m_reads = 0;
    int unsigned m_emit  = 0;
    logic        m_busy = 1'b0, e1 = 1'b0, e2 = 1'b0;
    logic        m_en = 1'b0, m_done = 1'b0, m_fd = 1'b0;
    logic        m_sof = 1'b0, m_eol = 1'b0, m_eof = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [23:0] m_pix = '0;

    rgb_pixel_streamer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .hold_i       (hold),
        .mem_en_o     (mem_en),
        .mem_addr_o   (mem_addr),
        .mem_data_i   (mem_data),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue),
        .done_o       (done),
        .sof_o        (sof),
        .eol_o        (eol),
        .eof_o        (eof),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_en) mem_data <= {mem_addr[7:0], ~mem_addr[7:0], 8'hA5};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Frame semantics: a read leaves on the first accepted start and on every
    // un-held edge until W*H reads; each read returns as a pixel two edges later.
    task automatic model_update();
        logic       en_new, done_new, fd_new;
        logic [7:0] a;
        int unsigned idx;
        if (rst) begin
            m_reads = 0; m_emit = 0; m_busy = 1'b0; e1 = 1'b0; e2 = 1'b0;
            m_en = 1'b0; m_done = 1'b0; m_fd = 1'b0; m_addr = '0;
            m_sof = 1'b0; m_eol = 1'b0; m_eof = 1'b0; m_pix = '0;
            return;
        end
        fd_new = m_done && m_eof;
        en_new = 1'b0;
        if (!m_busy && start) begin
            en_new = 1'b1; m_addr = AW'(BASE); m_reads = 1; m_emit = 0; m_busy = 1'b1;
        end else if (m_busy && m_reads < NPIX && !hold) begin
            en_new = 1'b1; m_addr = AW'(BASE + m_reads); m_reads++;
        end
        done_new = e2;
        idx = m_emit;
        if (done_new) begin
            a     = 8'(BASE + idx);
            m_pix = {a, ~a, 8'hA5};
            m_sof = (idx == 0);
            m_eol = (idx % W == W - 1);
            m_eof = (idx == NPIX - 1);
            m_emit++;
        end else begin
            m_pix = '0; m_sof = 1'b0; m_eol = 1'b0; m_eof = 1'b0;
        end
        e2 = e1; e1 = en_new;
        m_en = en_new; m_done = done_new; m_fd = fd_new;
        if (fd_new) m_busy = 1'b0;
    endtask

    task automatic compare();
        check("mem_en", 32'(mem_en), 32'(m_en));
        if (m_en) check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("done", 32'(done), 32'(m_done));
        check("pixel", 32'({red, green, blue}), 32'(m_pix));
        check("flags", 32'({sof, eol, eof}), 32'({m_sof, m_eol, m_eof}));
        check("busy", 32'(busy), 32'(m_busy));
        check("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    initial begin
        // Reset with start asserted
        rst = 1'b1; start = 1'b1;
        repeat (3) tick();
        check("reset_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0; start = 1'b0;
        repeat (2) tick();

        // Basic frame, no hold
        start = 1'b1; tick(); start = 1'b0;
        repeat (13) tick();
        check("basic_count", m_emit, NPIX);

        // Hold for 3 edges after the third read
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        hold = 1'b1; repeat (3) tick(); hold = 1'b0;
        repeat (12) tick();

        // start held high across frames
        start = 1'b1; repeat (25) tick(); start = 1'b0;
        repeat (12) tick();

        // Reset mid-frame, then restart
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20 && m_emit < 5; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (2) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (14) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 6 == 0);
            hold  = ($urandom % 3 == 0);
            rst   = ($urandom % 120 == 0);
            tick();
        end
        start = 1'b0; hold = 1'b0; rst = 1'b0;
        repeat (15) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
